// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer.
// Owns the 128-bit cipher state, applies AddRoundKey, and steps one external
// round datapath through NR rounds per block behind a valid/ready stream.
// Optional build feature: define AES_CTRL_ABORT_EN to add an 'abort' input
// that drops the block in flight and returns to IDLE.
module aes_round_ctrl #(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  input  logic           in_mode,
  output logic [RKW-1:0] rk_idx,
  input  logic [127:0]   rk_data,
  output logic [127:0]   rnd_data,
  input  logic [127:0]   rnd_result,
  output logic           mix_bypass,
  output logic           mode,
`ifdef AES_CTRL_ABORT_EN
  input  logic           abort,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy
);

  localparam logic [RKW-1:0] NR_IDX = RKW'(NR);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [127:0]   state_reg;
  logic [RKW-1:0] rnd_cnt;
  logic           mode_q;
  logic           abort_req;

`ifdef AES_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign rnd_data = state_reg;
  assign mode     = mode_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus all handshake, key-index and mix-columns controls.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    mix_bypass = 1'b0;
    rk_idx     = '0;
    out_data   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = in_mode ? NR_IDX : '0;
        if (in_valid) begin
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        busy       = 1'b1;
        rk_idx     = mode_q ? (NR_IDX - rnd_cnt) : rnd_cnt;
        mix_bypass = (rnd_cnt == NR_IDX);
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (rnd_cnt == NR_IDX) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = state_reg;
        if (abort_req || out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Cipher state, round counter and latched mode; the counter saturates at NR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      rnd_cnt   <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_data ^ rk_data;
            mode_q    <= in_mode;
            rnd_cnt   <= RKW'(1);
          end
        end
        ROUND: begin
          if (abort_req) begin
            state_reg <= '0;
            rnd_cnt   <= '0;
          end else begin
            state_reg <= rnd_result ^ rk_data;
            if (rnd_cnt != NR_IDX) begin
              rnd_cnt <= rnd_cnt + RKW'(1);
            end
          end
        end
        DONE: begin
          if (abort_req) begin
            state_reg <= '0;
            rnd_cnt   <= '0;
          end else if (out_ready) begin
            rnd_cnt <= '0;
          end
        end
        default: begin
          rnd_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl (AES-128, NR=10).
// Supplies a golden round datapath and key store (equivalent-inverse keys for
// decrypt) and checks results against a textbook AES encrypt/decrypt model.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

  localparam int NR  = 10;
  localparam int RKW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic           in_mode;
  logic [RKW-1:0] rk_idx;
  logic [127:0]   rk_data;
  logic [127:0]   rnd_data;
  logic [127:0]   rnd_result;
  logic           mix_bypass;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           busy;
`ifdef AES_CTRL_ABORT_EN
  logic           abort;
`endif

  aes_round_ctrl #(.NR(NR), .RKW(RKW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .rnd_data   (rnd_data),
    .rnd_result (rnd_result),
    .mix_bypass (mix_bypass),
    .mode       (mode),
`ifdef AES_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [31:0]  w     [44];
  logic [127:0] ek    [NR+1];
  logic [127:0] dk    [NR+1];
  logic         tables_ready = 1'b0;

  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;
  logic [127:0] exp_q[$];
  int           acc_cyc   = 0;
  logic         cur_mode  = 1'b0;
  logic         inflight  = 1'b0;
  logic         lat_done  = 1'b0;

  // ---------------- AES helper functions ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox[getb(s, i)] : sbox[getb(s, i)];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    int src;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - row + 4) % 4 : (c + row) % 4;
        r[127-8*(row+4*c) -: 8] = getb(s, row + 4*src);
      end
    return r;
  endfunction

  function automatic logic [7:0] coef(input int k, input logic inv);
    case (k)
      0:       return inv ? 8'd14 : 8'd2;
      1:       return inv ? 8'd11 : 8'd3;
      2:       return inv ? 8'd13 : 8'd1;
      default: return inv ? 8'd9  : 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   b;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = getb(s, 4*c + j);
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(coef((j - row + 4) % 4, inv), a[j]);
        r[127-8*(row+4*c) -: 8] = b;
      end
    end
    return r;
  endfunction

  // Textbook AES-128 cipher and inverse cipher (reference model).
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ ek[0];
    for (int r = 1; r < NR; r++) s = mix(shift_rows(sub_bytes(s, 0), 0), 0) ^ ek[r];
    return shift_rows(sub_bytes(s, 0), 0) ^ ek[NR];
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ ek[NR];
    for (int r = NR - 1; r >= 1; r--) s = mix(sub_bytes(shift_rows(s, 1), 1) ^ ek[r], 1);
    return sub_bytes(shift_rows(s, 1), 1) ^ ek[0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Golden external key store and round datapath, both combinational.
  always_comb begin
    rk_data    = '0;
    rnd_result = '0;
    if (tables_ready) begin
      if (int'(rk_idx) <= NR) rk_data = mode ? dk[int'(rk_idx)] : ek[int'(rk_idx)];
      if (mode)
        rnd_result = mix_bypass ? sub_bytes(shift_rows(rnd_data, 1), 1)
                                : mix(sub_bytes(shift_rows(rnd_data, 1), 1), 1);
      else
        rnd_result = mix_bypass ? shift_rows(sub_bytes(rnd_data, 0), 0)
                                : mix(shift_rows(sub_bytes(rnd_data, 0), 0), 0);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check_int(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got timeout/unexpected event expected normal progress (cycle %0d)", name, cyc);
  endtask

  // Monitor: per-round control checks, latency check, and scoreboard pop on output handshake.
  always @(negedge clk) begin : monitor
    int r;
    if (!rst && tables_ready) begin
      if (inflight) begin
        r = cyc - acc_cyc;
        if (r >= 1 && r <= NR) begin
          check_int("rk_idx_round", int'(rk_idx), cur_mode ? NR - r : r);
          check_int("mix_bypass", int'(mix_bypass), int'(r == NR));
          check_int("mode_latched", int'(mode), int'(cur_mode));
          check_int("round_flags", int'({busy, in_ready, out_valid}), 4);
        end
        if (out_valid && !lat_done) begin
          check_int("latency", r, NR + 1);
          lat_done = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          check_vec("out_data", out_data, exp_q.pop_front());
          inflight = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_block(input logic [127:0] data, input logic m, input logic [127:0] expv);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_data  = data;
    in_mode  = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    check_int("rk_idx_idle", int'(rk_idx), m ? NR : 0);
    exp_q.push_back(expv);
    acc_cyc  = cyc;
    cur_mode = m;
    inflight = 1'b1;
    lat_done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rand128();
    in_mode  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      inflight = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_int({tag, "_in_ready"}, int'(in_ready), 1);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_out_valid"}, int'(out_valid), 0);
    check_int({tag, "_mix_bypass"}, int'(mix_bypass), 0);
    check_vec({tag, "_out_data"}, out_data, 128'h0);
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin : stim
    logic [7:0]   inv, s, rc;
    logic [31:0]  t;
    logic [127:0] key, d, bp_exp;
    logic         m;
    int           a0, a1, a2;
    bit           seen;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
`ifdef AES_CTRL_ABORT_EN
    abort = 1'b0;
`endif

    // Build S-boxes from GF(2^8) inverse plus affine map.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
          ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    // AES-128 key expansion for key 000102..0f.
    key = 128'h000102030405060708090a0b0c0d0e0f;
    rc  = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) begin
      ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      dk[r] = (r == 0 || r == NR) ? ek[r] : mix(ek[r], 1'b1);
    end
    tables_ready = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_int("reset_rk_idx", int'(rk_idx), 0);
    check_int("reset_mode", int'(mode), 0);
    rst = 1'b0;

    // FIPS-197 C.1 encrypt and decrypt.
    send_block(128'h00112233445566778899aabbccddeeff, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_drain();
    send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 128'h00112233445566778899aabbccddeeff);
    wait_drain();

    // Backpressure: hold DONE for several cycles with in_valid pulses.
    out_ready = 1'b0;
    d = rand128(); m = 1'($urandom_range(0, 1));
    bp_exp = m ? aes_dec(d) : aes_enc(d);
    send_block(d, m, bp_exp);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) fail_now("bp_out_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k % 2 == 0);
      in_data  = rand128();
      @(negedge clk);
      check_int("bp_out_valid", int'(out_valid), 1);
      check_vec("bp_hold_data", out_data, bp_exp);
      check_int("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_int("bp_release_in_ready", int'(in_ready), 1);
    check_int("bp_release_out_valid", int'(out_valid), 0);
    wait_drain();

    // Back-to-back blocks with out_ready held high.
    d = rand128(); m = 1'($urandom_range(0, 1));
    send_block(d, m, m ? aes_dec(d) : aes_enc(d)); a0 = acc_cyc;
    d = rand128(); m = 1'($urandom_range(0, 1));
    send_block(d, m, m ? aes_dec(d) : aes_enc(d)); a1 = acc_cyc;
    d = rand128(); m = 1'($urandom_range(0, 1));
    send_block(d, m, m ? aes_dec(d) : aes_enc(d)); a2 = acc_cyc;
    check_int("b2b_gap1", a1 - a0, NR + 2);
    check_int("b2b_gap2", a2 - a1, NR + 2);
    wait_drain();

    // Synchronous reset in the middle of round 5 of a decrypt block.
    d = rand128();
    send_block(d, 1'b1, aes_dec(d));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc - acc_cyc >= 5) break;
    end
    rst = 1'b1; in_mode = 1'b0;
    exp_q.delete(); inflight = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    check_int("midrst_mode", int'(mode), 0);
    rst = 1'b0;
    d = rand128();
    send_block(d, 1'b0, aes_enc(d));
    wait_drain();

`ifdef AES_CTRL_ABORT_EN
    // Abort during round 3: no output, then a normal block.
    d = rand128();
    send_block(d, 1'b0, aes_enc(d));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc - acc_cyc >= 3) break;
    end
    abort = 1'b1;
    exp_q.delete(); inflight = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_int("abort_in_ready", int'(in_ready), 1);
    check_int("abort_busy", int'(busy), 0);
    seen = 0;
    for (int i = 0; i < NR + 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_int("abort_no_output", int'(seen), 0);
    d = rand128();
    send_block(d, 1'b1, aes_dec(d));
    wait_drain();
`endif

    // Randomized blocks with random release delay of out_ready.
    for (int n = 0; n < 12; n++) begin
      out_ready = 1'b0;
      d = rand128(); m = 1'($urandom_range(0, 1));
      send_block(d, m, m ? aes_dec(d) : aes_enc(d));
      repeat (NR + $urandom_range(0, 4)) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
